// File: rtl/aexm_mem_arbiter.sv
// aexm_mem_arbiter: shares one external memory burst port between the
// instruction cache (read-only line fills) and the data cache (line fills
// and write-backs). Two requesters are arbitrated round-robin. Each grant
// issues one burst command, moves BURST_LEN beats and pulses the owner's done.
//
// Ports
//   CLK, grst_n                      clock, asynchronous active-low reset
//   ic_req/ic_addr/ic_done           icache request side
//   dc_req/dc_we/dc_addr/dc_wdata    dcache request side
//   dc_wack/dc_done                  dcache write-beat accept, completion
//   rdata/ic_rvalid/dc_rvalid        registered read beat and its owner
//   mem_cmd_*                        burst command handshake
//   mem_wdata/mem_wvalid/mem_wready  write beat handshake
//   mem_rdata/mem_rvalid             read beat from memory
//   busy                             high whenever a burst is in flight
module aexm_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int BEAT_W    = 2
) (
  input  logic              CLK,
  input  logic              grst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wack,
  output logic              dc_done,
  output logic [DATA_W-1:0] rdata,
  output logic              ic_rvalid,
  output logic              dc_rvalid,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  localparam int OFF_W = $clog2(BURST_LEN * DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, CMD, RD, WR, DONE} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t            state, state_nx;
  owner_t            owner, last_owner, grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] beat;
  logic              rd_beat, wr_beat;

  // On a tie the requester that did not own the previous burst wins.
  always_comb begin
    grant = OWN_IC;
    if (dc_req && (!ic_req || last_owner == OWN_IC))
      grant = OWN_DC;
  end

  assign rd_beat = (state == RD) && mem_rvalid;
  assign wr_beat = (state == WR) && mem_wready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ic_req || dc_req) state_nx = CMD;
      CMD:  if (mem_cmd_ready)    state_nx = we_q ? WR : RD;
      RD:   if (rd_beat && beat == LAST_BEAT) state_nx = DONE;
      WR:   if (wr_beat && beat == LAST_BEAT) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge grst_n) begin
    if (!grst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge CLK or negedge grst_n) begin
    if (!grst_n) begin
      owner      <= OWN_IC;
      last_owner <= OWN_IC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      beat       <= '0;
      rdata      <= '0;
      ic_rvalid  <= 1'b0;
      dc_rvalid  <= 1'b0;
    end else begin
      ic_rvalid <= rd_beat && (owner == OWN_IC);
      dc_rvalid <= rd_beat && (owner == OWN_DC);
      if (rd_beat) rdata <= mem_rdata;
      case (state)
        IDLE: if (ic_req || dc_req) begin
          owner  <= grant;
          we_q   <= (grant == OWN_DC) && dc_we;
          addr_q <= ((grant == OWN_DC) ? dc_addr : ic_addr) & ALIGN_MASK;
        end
        CMD:  if (mem_cmd_ready) beat <= '0;
        RD:   if (rd_beat) beat <= beat + BEAT_W'(1);
        WR:   if (wr_beat) beat <= beat + BEAT_W'(1);
        DONE: last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign mem_cmd_valid = (state == CMD);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_wvalid    = (state == WR);
  assign mem_wdata     = (state == WR) ? dc_wdata : '0;
  assign dc_wack       = wr_beat;
  // done is decoded from DONE so a requester that drops on done is already
  // low by the following IDLE cycle and cannot be re-granted by mistake.
  assign ic_done       = (state == DONE) && (owner == OWN_IC);
  assign dc_done       = (state == DONE) && (owner == OWN_DC);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_aexm_mem_arbiter.sv
module tb_aexm_mem_arbiter;

  logic        CLK = 1'b0;
  logic        grst_n;
  logic        ic_req, dc_req, dc_we;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_done, dc_done, dc_wack;
  logic [31:0] rdata;
  logic        ic_rvalid, dc_rvalid;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
  logic [31:0] mem_cmd_addr, mem_wdata, mem_rdata;
  logic        mem_wvalid, mem_wready, mem_rvalid;
  logic        busy;

  aexm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .BEAT_W(2)) dut (
    .CLK(CLK), .grst_n(grst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wack(dc_wack), .dc_done(dc_done),
    .rdata(rdata), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory-side behaviour knobs (percent probabilities).
  int unsigned rdy_pct = 100, rv_pct = 100, wr_pct = 100;
  bit          wr_toggle = 1'b0;
  bit          auto_req  = 1'b0;

  initial begin
    mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_wready = 1'b0;
    mem_rdata = '0; dc_wdata = '0;
    forever begin
      @(negedge CLK);
      mem_cmd_ready = ($urandom_range(99) < rdy_pct);
      mem_rvalid    = ($urandom_range(99) < rv_pct);
      mem_wready    = wr_toggle ? !mem_wready : ($urandom_range(99) < wr_pct);
      mem_rdata     = $urandom;
      dc_wdata      = $urandom;
    end
  end

  // Random requesters: hold each request until its done, then maybe re-request.
  initial begin
    forever begin
      @(negedge CLK);
      if (auto_req) begin
        if (!grst_n) begin
          ic_req = 1'b0; dc_req = 1'b0;
        end else begin
          if (ic_req) begin
            if (ic_done) begin
              if ($urandom_range(3) != 0) ic_req = 1'b0;
              else ic_addr = $urandom;
            end
          end else if ($urandom_range(3) == 0) begin
            ic_req = 1'b1; ic_addr = $urandom;
          end
          if (dc_req) begin
            if (dc_done) begin
              if ($urandom_range(3) != 0) dc_req = 1'b0;
              else begin dc_addr = $urandom; dc_we = 1'($urandom_range(1)); end
            end
          end else if ($urandom_range(3) == 0) begin
            dc_req = 1'b1; dc_addr = $urandom; dc_we = 1'($urandom_range(1));
          end
        end
      end
    end
  end

  // Transaction-level reference: one in-flight burst record plus history.
  bit          m_active, m_cmd_pending, m_fin, m_own_dc, m_we, m_last_dc;
  int          m_beats;
  logic [31:0] m_addr, m_rdata;
  bit          m_icrv, m_dcrv;
  bit          grants[$];   // model grant order, 1 = dcache
  bit          done_log[$]; // observed DUT done order, 1 = dcache

  initial begin
    forever begin
      @(posedge CLK);
      if (!grst_n) begin
        m_active = 0; m_cmd_pending = 0; m_fin = 0; m_own_dc = 0; m_we = 0;
        m_last_dc = 0; m_beats = 0; m_addr = '0; m_rdata = '0;
        m_icrv = 0; m_dcrv = 0;
      end else begin
        m_icrv = 0; m_dcrv = 0;
        if (m_active && !m_cmd_pending && !m_fin && !m_we && mem_rvalid) begin
          m_rdata = mem_rdata;
          if (m_own_dc) m_dcrv = 1; else m_icrv = 1;
        end
        if (!m_active) begin
          if (ic_req || dc_req) begin
            m_own_dc = dc_req && (!ic_req || !m_last_dc);
            m_we     = m_own_dc ? dc_we : 1'b0;
            m_addr   = (m_own_dc ? dc_addr : ic_addr) & 32'hFFFF_FFF0;
            m_active = 1; m_cmd_pending = 1; m_fin = 0;
            grants.push_back(m_own_dc);
          end
        end else if (m_cmd_pending) begin
          if (mem_cmd_ready) begin m_cmd_pending = 0; m_beats = 0; end
        end else if (m_fin) begin
          m_last_dc = m_own_dc; m_active = 0; m_fin = 0;
        end else if (m_we ? mem_wready : mem_rvalid) begin
          m_beats++;
          if (m_beats == 4) m_fin = 1;
        end
      end
      #1;
      begin
        bit dv, wv;
        dv = m_active && !m_cmd_pending && !m_fin;
        wv = dv && m_we;
        chk("busy",      64'(busy),          64'(m_active));
        chk("cmd_valid", 64'(mem_cmd_valid), 64'(m_active && m_cmd_pending));
        chk("cmd_we",    64'(mem_cmd_we),    64'(m_we));
        chk("cmd_addr",  64'(mem_cmd_addr),  64'(m_addr));
        chk("wvalid",    64'(mem_wvalid),    64'(wv));
        chk("wdata",     64'(mem_wdata),     wv ? 64'(dc_wdata) : 64'h0);
        chk("dc_wack",   64'(dc_wack),       64'(wv && mem_wready));
        chk("ic_rvalid", 64'(ic_rvalid),     64'(m_icrv));
        chk("dc_rvalid", 64'(dc_rvalid),     64'(m_dcrv));
        chk("rdata",     64'(rdata),         64'(m_rdata));
        chk("ic_done",   64'(ic_done),       64'(m_active && m_fin && !m_own_dc));
        chk("dc_done",   64'(dc_done),       64'(m_active && m_fin && m_own_dc));
        chk("rv_excl",   64'(ic_rvalid & dc_rvalid), 64'h0);
      end
      if (ic_done) done_log.push_back(1'b0);
      if (dc_done) done_log.push_back(1'b1);
    end
  end

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  // Run until n done pulses; drop each finished request unless hold is set.
  task automatic serve(input int n, input bit hold, output int idle, output int icrv,
                       output int dcrv, output int wacks);
    int got = 0;
    idle = 0; icrv = 0; dcrv = 0; wacks = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      tick();
      if (!busy) idle++;
      if (ic_rvalid) icrv++;
      if (dc_rvalid) dcrv++;
      if (dc_wack) begin
        wacks++;
        chk("wdata_pass", 64'(mem_wdata), 64'(dc_wdata));
      end
      if (ic_done) begin got++; if (!hold) ic_req = 1'b0; end
      if (dc_done) begin got++; if (!hold) dc_req = 1'b0; end
    end
    if (got < n) chk("serve_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    int idle, icrv, dcrv, wacks, seen;
    grst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0;
    repeat (3) tick();
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_cmd",   64'(mem_cmd_valid), 64'h0);
    grst_n = 1'b1;
    tick();

    // Simultaneous requests after reset: dcache first.
    grants.delete(); done_log.delete();
    ic_addr = 32'h1234; dc_addr = 32'h88; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    tick();
    chk("t1_cmd_addr", 64'(mem_cmd_addr), 64'h80);
    serve(2, 1'b0, idle, icrv, dcrv, wacks);
    chk("t1_done_n",   64'(done_log.size()), 64'd2);
    if (done_log.size() == 2) begin
      chk("t1_first",  64'(done_log[0]), 64'd1);
      chk("t1_second", 64'(done_log[1]), 64'd0);
    end
    chk("t1_idle",     64'(idle), 64'd1);
    chk("t1_model_grants", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) chk("t1_model_g0", 64'(grants[0]), 64'd1);
    chk("t1_dcrv", 64'(dcrv), 64'd4);
    chk("t1_icrv", 64'(icrv), 64'd4);
    tick();

    // Both held continuously for four bursts.
    grants.delete(); done_log.delete();
    dc_we = 1'b1; ic_req = 1'b1; dc_req = 1'b1;
    serve(4, 1'b1, idle, icrv, dcrv, wacks);
    ic_req = 1'b0; dc_req = 1'b0;
    chk("t5_idle", 64'(idle), 64'd3);
    chk("t5_wacks", 64'(wacks), 64'd8);
    chk("t5_done_n", 64'(done_log.size()), 64'd4);
    if (done_log.size() == 4)
      chk("t5_order", 64'({done_log[0], done_log[1], done_log[2], done_log[3]}), 64'b1010);
    if (grants.size() == 4)
      chk("t5_model_order", 64'({grants[0], grants[1], grants[2], grants[3]}), 64'b1010);
    tick();

    // icache line fill, unaligned address.
    ic_addr = 32'h1234; ic_req = 1'b1;
    tick();
    chk("t2_addr", 64'(mem_cmd_addr), 64'h1230);
    chk("t2_we",   64'(mem_cmd_we), 64'h0);
    serve(1, 1'b0, idle, icrv, dcrv, wacks);
    chk("t2_icrv", 64'(icrv), 64'd4);
    chk("t2_dcrv", 64'(dcrv), 64'd0);
    tick();

    // dcache write-back with wready toggling.
    wr_toggle = 1'b1; dc_addr = 32'h80; dc_we = 1'b1; dc_req = 1'b1;
    tick();
    chk("t3_addr", 64'(mem_cmd_addr), 64'h80);
    chk("t3_we",   64'(mem_cmd_we), 64'h1);
    serve(1, 1'b0, idle, icrv, dcrv, wacks);
    chk("t3_wacks", 64'(wacks), 64'd4);
    wr_toggle = 1'b0;
    tick();

    // Command held off for five cycles.
    rdy_pct = 0; ic_addr = 32'hABCD_0104; ic_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid", 64'(mem_cmd_valid), 64'h1);
      chk("t4_addr",  64'(mem_cmd_addr), 64'hABCD_0100);
      chk("t4_we",    64'(mem_cmd_we), 64'h0);
      chk("t4_norv",  64'(ic_rvalid), 64'h0);
    end
    rdy_pct = 100;
    serve(1, 1'b0, idle, icrv, dcrv, wacks);
    chk("t4_icrv", 64'(icrv), 64'd4);
    tick();

    // Reset in the middle of a read burst.
    ic_addr = 32'h40; ic_req = 1'b1; seen = 0;
    for (int c = 0; c < 50 && seen < 2; c++) begin
      tick();
      if (ic_rvalid) seen++;
    end
    chk("t6_beats_before", 64'(seen), 64'd2);
    grst_n = 1'b0;
    #1;
    chk("t6_busy",  64'(busy), 64'h0);
    chk("t6_rv",    64'(ic_rvalid), 64'h0);
    chk("t6_rdata", 64'(rdata), 64'h0);
    chk("t6_cmd",   64'(mem_cmd_addr), 64'h0);
    ic_req = 1'b0; seen = 0;
    repeat (2) begin
      tick();
      if (ic_done || dc_done) seen++;
    end
    chk("t6_nodone", 64'(seen), 64'd0);
    grst_n = 1'b1;
    tick();
    done_log.delete();
    dc_addr = 32'h200; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
    tick();
    chk("t6_dc_first", 64'(mem_cmd_addr), 64'h200);
    serve(2, 1'b0, idle, icrv, dcrv, wacks);
    chk("t6_dcrv", 64'(dcrv), 64'd4);
    chk("t6_icrv", 64'(icrv), 64'd4);
    if (done_log.size() == 2) chk("t6_order", 64'({done_log[0], done_log[1]}), 64'b10);
    else chk("t6_done_n", 64'(done_log.size()), 64'd2);
    tick();

    // Randomised traffic with occasional resets.
    auto_req = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        rdy_pct = $urandom_range(100, 30);
        rv_pct  = $urandom_range(100, 30);
        wr_pct  = $urandom_range(100, 30);
      end
      tick();
      if ($urandom_range(299) == 0) begin
        grst_n = 1'b0;
        tick(); tick();
        grst_n = 1'b1;
      end
    end
    auto_req = 1'b0;
    ic_req = 1'b0; dc_req = 1'b0;
    rdy_pct = 100; rv_pct = 100; wr_pct = 100;
    repeat (20) tick();
    chk("end_idle", 64'(busy), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
